// File: rtl/mdc_pkg.sv
// Purpose : shared constants, sample type and size helpers for the radix-2 MDC FFT pipeline.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package mdc_pkg;

  // Default pipeline geometry; blocks take these as parameter defaults.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N          = 16;

  // Derived geometry for the default frame length.
  localparam int HALF   = DEF_N / 2;
  localparam int CNT_W  = $clog2(DEF_N);
  localparam int ADDR_W = $clog2(DEF_N / 2);

  // Shared sample type; samples are passed through unmodified.
  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

  // Geometry helpers for blocks instantiated with a non-default N.
  function automatic int half_of(input int n);
    return n / 2;
  endfunction

  function automatic int cnt_bits(input int n);
    return $clog2(n);
  endfunction

  function automatic int addr_bits(input int n);
    return $clog2(n / 2);
  endfunction

endpackage

// File: rtl/half_frame_buf.sv
// Purpose : N/2-deep register array holding the first half of a frame.
// Latency : write lands on the next posedge; read is combinational.
// Backpressure: none, one write and one read per cycle.
//
// Ports: clk; wr_en/wr_addr/wr_data synchronous write; rd_addr in, rd_data out (async read).
// Storage has no reset: contents are only read after being written in the same frame.
module half_frame_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mdc_input_splitter.sv
// Purpose : splits a serial N-point frame into parallel (x[i], x[i+N/2]) pairs for dc_top.
// Latency : 1 clock from acceptance of x[i+N/2] to the registered pair on x0/x1.
// Backpressure: none; every in_valid sample is accepted, input gaps become out_valid gaps.
//
// Ports: clk, reset (async, active-low); in_data/in_valid/in_sop serial input;
//        x0/x1/out_valid/out_sop registered pair output; frame_err one-cycle misalignment pulse.
module mdc_input_splitter
  import mdc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic [DATA_WIDTH-1:0] x0,
  output logic [DATA_WIDTH-1:0] x1,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  frame_err
);

  localparam int HALF_LEN  = half_of(N);
  localparam int CNT_BITS  = cnt_bits(N);
  localparam int ADDR_BITS = addr_bits(N);

  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] x0_q, x0_d;
  logic [DATA_WIDTH-1:0] x1_q, x1_d;
  logic                  vld_q, vld_d;
  logic                  sop_q, sop_d;
  logic                  err_q, err_d;

  logic                  buf_we;
  logic [ADDR_BITS-1:0]  buf_waddr;
  logic [DATA_WIDTH-1:0] buf_rdata;

  // cnt MSB selects FILL (0) / PAIR (1); the low bits address the buffer in both
  // phases, so in PAIR they already equal cnt - N/2.
  logic                 pair_phase;
  logic [ADDR_BITS-1:0] addr;

  assign pair_phase = cnt_q[CNT_BITS-1];
  assign addr       = cnt_q[ADDR_BITS-1:0];

  half_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF_LEN),
    .ADDR_W     (ADDR_BITS)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (in_data),
    .rd_addr (addr),
    .rd_data (buf_rdata)
  );

  always_comb begin
    cnt_d     = cnt_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    vld_d     = 1'b0;
    sop_d     = 1'b0;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = addr;

    if (in_valid) begin
      if (in_sop) begin
        // Forced realignment: this sample is x[0] regardless of where cnt was.
        // Any partial frame is dropped and no pair is produced for it.
        buf_we    = 1'b1;
        buf_waddr = '0;
        cnt_d     = CNT_BITS'(1);
        err_d     = (cnt_q != '0);
      end else if (!pair_phase) begin
        buf_we = 1'b1;
        cnt_d  = cnt_q + CNT_BITS'(1);
      end else begin
        x0_d  = buf_rdata;
        x1_d  = in_data;
        vld_d = 1'b1;
        sop_d = (addr == '0);
        // Natural wrap N-1 -> 0 starts the next frame with no idle cycle.
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      vld_q <= 1'b0;
      sop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      x0_q  <= x0_d;
      x1_q  <= x1_d;
      vld_q <= vld_d;
      sop_q <= sop_d;
      err_q <= err_d;
    end
  end

  assign x0        = x0_q;
  assign x1        = x1_q;
  assign out_valid = vld_q;
  assign out_sop   = sop_q;
  assign frame_err = err_q;

endmodule

// File: doc/mdc_input_splitter.md
Name: mdc_input_splitter

Overview:
- Input stage of the radix-2 MDC FFT pipeline; sits directly upstream of dc_top.
- Accepts a serial stream of N-point frames, one sample per accepted cycle.
- Emits the two half-frame streams in parallel: pairs (x[i], x[i+N/2]) for i = 0..N/2-1, on consecutive cycles when input is gap-free.
- Stores the first half-frame in an N/2-entry buffer and pairs each buffered entry with the live second-half sample.

Parameters:
- DATA_WIDTH, 32, sample width in bits; data is passed through unmodified.
- N, 16, FFT frame length; power of two, N >= 4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  serial sample.
- in_valid  input  1  in_data is accepted this cycle. No backpressure: the block always accepts.
- in_sop  input  1  qualified by in_valid; marks sample 0 of a frame.
- x0  output  DATA_WIDTH  first-half sample x[i]; feeds dc_top x0.
- x1  output  DATA_WIDTH  second-half sample x[i+N/2]; feeds dc_top x1.
- out_valid  output  1  x0/x1 hold a valid pair.
- out_sop  output  1  marks pair i = 0.
- frame_err  output  1  one-cycle pulse on frame misalignment.

Behaviour:
- Reset (reset = 0, asynchronous): cnt = 0, x0 = x1 = 0, out_valid = out_sop = frame_err = 0. Buffer contents are don't-care.
- State:
  - cnt, $clog2(N) bits, counts samples accepted in the current frame.
  - Phase FILL when cnt < N/2; phase PAIR otherwise.
  - The MSB of cnt is the phase bit; the LSBs are the buffer address.
- Accepted sample in FILL: buf[cnt] <= in_data; cnt++.
- Accepted sample in PAIR:
  - Next cycle: x0 <= buf[cnt - N/2], x1 <= in_data, out_valid <= 1.
  - out_sop <= (cnt == N/2).
  - cnt++, wrapping N-1 -> 0. The next frame begins immediately, with no idle cycle required.
- Latency: one clock from acceptance of x[i+N/2] to the registered pair on x0/x1.
- Buffer read is combinational from the register array. The same slot is never read and written in the same cycle, because the phases are disjoint.
- Cycle with in_valid = 0: cnt holds; out_valid <= 0 and out_sop <= 0 next cycle; x0/x1 hold their last values.
- Gaps inside PAIR therefore appear as out_valid gaps. dc_top requires a gap-free PAIR phase, which is the upstream source's responsibility.
- in_sop with in_valid = 1:
  - The sample is treated as x[0]: written to buf[0], and cnt <= 1. This overrides the normal increment.
  - If cnt != 0 at that moment, frame_err <= 1 for one cycle and the partial frame is discarded. Pairs already emitted stand.
  - If cnt is in PAIR, no pair is emitted for that sample.
- in_sop with in_valid = 0 is ignored.
- in_sop absent: frames are delimited purely by cnt wrap. in_sop is optional after the first frame.
- Reset asserted mid-frame: all state clears at once; the partial frame is lost and out_valid drops asynchronously.
- Across an N-sample frame there are exactly N/2 out_valid cycles, all in the second half. Throughput is N/2 pairs per N input cycles.

Decomposition:
- Package mdc_pkg:
  - localparams derived from N: HALF = N/2, CNT_W = $clog2(N), ADDR_W = $clog2(N/2).
  - Shared sample typedef: logic [DATA_WIDTH-1:0].
  - Used also by dc_top and the butterfly stages.
- One sub-module, half_frame_buf:
  - N/2 x DATA_WIDTH register array; synchronous write port, asynchronous read port.
  - No reset on the storage.
- Counter, phase logic and output registers stay in mdc_input_splitter.

Test Plan (N = 16, DATA_WIDTH = 32):
- Reset low for 2 cycles, then release with in_valid = 0 -> all outputs 0, cnt = 0, no out_valid.
- in_sop on the first sample, stream 0..15 gap-free -> out_valid high for exactly 8 consecutive cycles starting 1 cycle after sample 8 is accepted. Pairs (0,8), (1,9) ... (7,15); out_sop only on (0,8); frame_err stays 0.
- Two back-to-back frames 0..15 then 100..115, with in_sop only on sample 0 -> second frame emits (100,108) ... (107,115) with out_sop on (100,108).
- Frame 0..15 with in_valid low for 2 cycles after sample 10 -> pairs (0,8), (1,9), (2,10), then 2 cycles of out_valid = 0 with x0/x1 held at (2,10), then (3,11) ... (7,15).
- in_sop asserted on the sample following 11, with in_data = 50 (cnt = 12) -> frame_err pulses once; no pair is emitted for 50. The following samples 51..65 form a new frame giving pairs (50,58) ... (57,65).
- Reset asserted asynchronously during the PAIR phase after pair (3,11) -> out_valid drops immediately, x0/x1 = 0. After release, a fresh 0..15 frame produces the correct 8 pairs.
